// File: rtl/stall_ctrl_param.sv
// Pipeline stall controller: decodes the decode-stage opcode into fixed-length
// stall windows per instruction class, plus a latching HALT released externally.
module stall_ctrl_param #(
    parameter int unsigned OP_W    = 6,
    parameter logic [OP_W-1:0] JMP_OP = 6'b010100,
    parameter logic [OP_W-1:0] LD_OP  = 6'b011110,
    parameter logic [OP_W-1:0] HLT_OP = 6'b010001,
    parameter int unsigned JMP_CYC = 1,
    parameter int unsigned LD_CYC  = 2,
    parameter int unsigned CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  op,
    input  logic             release_halt,
    output logic             stall,
    output logic             stall_pm,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    // Cycle counts are truncated to the counter width; zero disables the class.
    localparam logic [CNT_W-1:0] JMP_N = CNT_W'(JMP_CYC);
    localparam logic [CNT_W-1:0] LD_N  = CNT_W'(LD_CYC);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, STALL, HALT} state_t;

    state_t           state_q, state_d;
    logic             stall_q, stall_d;
    logic             stall_pm_q, stall_pm_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ld_hit, jmp_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            stall_q    <= 1'b0;
            stall_pm_q <= 1'b0;
            halted_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            stall_q    <= stall_d;
            stall_pm_q <= stall_pm_d;
            halted_q   <= halted_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        ld_hit  = (op == LD_OP) && (LD_N != '0);
        jmp_hit = (op == JMP_OP) && (JMP_N != '0);
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (op == HLT_OP)        state_d = HALT;
                else if (ld_hit || jmp_hit) state_d = STALL;
            end
            STALL:   if (cnt_q == ONE) state_d = IDLE;
            HALT:    if (release_halt) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_d  = (state_d != IDLE);
        halted_d = (state_d == HALT);
        // HALT keeps the program memory frozen even though stall_q is already high.
        stall_pm_d = stall_q || (state_q == HALT);
        cnt_d = '0;
        case (state_q)
            IDLE: begin
                if (state_d == STALL) cnt_d = ld_hit ? LD_N : JMP_N;
            end
            STALL:   cnt_d = cnt_q - ONE;
            default: cnt_d = '0;
        endcase
    end

    assign stall     = stall_q;
    assign stall_pm  = stall_pm_q;
    assign halted    = halted_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_stall_ctrl_param.sv
// Bench for stall_ctrl_param: four parameterisations share one input stream and
// are checked against an edge-numbered window model.
module tb_stall_ctrl_param;

    localparam logic [5:0] JMP = 6'b010100;
    localparam logic [5:0] LD  = 6'b011110;
    localparam logic [5:0] HLT = 6'b010001;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       rel;
    logic       st[4];
    logic       pm[4];
    logic       hl[4];
    logic [3:0] cn0, cn1, cn2;
    logic [2:0] cn3;

    always #5 clk = ~clk;

    stall_ctrl_param u0 (.clk(clk), .reset(reset), .op(op), .release_halt(rel),
        .stall(st[0]), .stall_pm(pm[0]), .halted(hl[0]), .stall_cnt(cn0));
    stall_ctrl_param #(.LD_CYC(5)) u1 (.clk(clk), .reset(reset), .op(op), .release_halt(rel),
        .stall(st[1]), .stall_pm(pm[1]), .halted(hl[1]), .stall_cnt(cn1));
    stall_ctrl_param #(.JMP_CYC(0), .LD_CYC(7)) u2 (.clk(clk), .reset(reset), .op(op),
        .release_halt(rel), .stall(st[2]), .stall_pm(pm[2]), .halted(hl[2]), .stall_cnt(cn2));
    stall_ctrl_param #(.CNT_W(3), .JMP_CYC(8), .LD_CYC(9)) u3 (.clk(clk), .reset(reset),
        .op(op), .release_halt(rel), .stall(st[3]), .stall_pm(pm[3]), .halted(hl[3]),
        .stall_cnt(cn3));

    // Effective cycle counts after truncation to each instance's counter width.
    int jc[4] = '{1, 1, 0, 8 % 8};
    int lc[4] = '{2, 5, 7, 9 % 8};

    // Model: stall high in the cycles after edges e..su-1; next decode at edge nd.
    int  su[4];
    int  nd[4];
    bit  mh[4];
    bit  ps[4];
    int  ec;
    int  nvec;
    int  nerr;

    function automatic bit m_stall(int i);
        return mh[i] || (ec < su[i]);
    endfunction

    function automatic logic [3:0] m_cnt(int i);
        if (mh[i] || ec >= su[i]) return 4'd0;
        return 4'(su[i] - ec);
    endfunction

    function automatic logic [3:0] dut_cnt(int i);
        case (i)
            0: return cn0;
            1: return cn1;
            2: return cn2;
            default: return {1'b0, cn3};
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            su[i] = 0; nd[i] = 0; mh[i] = 1'b0; ps[i] = 1'b0;
        end
    endtask

    task automatic chk(string tag, int i, logic [3:0] obs, logic [3:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s[u%0d] edge %0d: got %0h expected %0h", tag, i, ec, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            chk("stall",    i, {3'b0, st[i]}, {3'b0, m_stall(i)});
            chk("stall_pm", i, {3'b0, pm[i]}, {3'b0, ps[i]});
            chk("halted",   i, {3'b0, hl[i]}, {3'b0, mh[i]});
            chk("stall_cnt", i, dut_cnt(i), m_cnt(i));
        end
    endtask

    task automatic step(logic [5:0] o, logic r);
        op  = o;
        rel = r;
        for (int i = 0; i < 4; i++) ps[i] = m_stall(i);
        @(posedge clk);
        ec++;
        for (int i = 0; i < 4; i++) begin
            if (mh[i]) begin
                if (r) begin
                    mh[i] = 1'b0;
                    nd[i] = ec + 1;
                end
            end else if (ec >= nd[i]) begin
                if (o == HLT) begin
                    mh[i] = 1'b1;
                end else if (o == LD && lc[i] > 0) begin
                    su[i] = ec + lc[i]; nd[i] = ec + lc[i] + 1;
                end else if (o == JMP && jc[i] > 0) begin
                    su[i] = ec + jc[i]; nd[i] = ec + jc[i] + 1;
                end
            end
        end
        #1;
        check_all();
    endtask

    // Asynchronous reset pulse applied between edges; outputs must clear at once.
    task automatic async_reset();
        #1 reset = 1'b1;
        model_reset();
        #1 check_all();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        nvec = 0; nerr = 0; ec = 0;
        op = '0; rel = 1'b0; reset = 1'b0;
        model_reset();
        @(posedge clk);
        async_reset();

        step(JMP, 1'b0);
        repeat (3) step('0, 1'b0);

        repeat (4) step(LD, 1'b0);
        repeat (3) step('0, 1'b0);

        step(HLT, 1'b0);
        for (int k = 0; k < 20; k++) step((k % 2 == 0) ? LD : JMP, 1'b0);
        step('0, 1'b1);
        repeat (3) step('0, 1'b0);

        step(LD, 1'b0);
        step('0, 1'b0);
        step('0, 1'b0);
        async_reset();
        repeat (2) step('0, 1'b0);

        step(JMP, 1'b0);
        repeat (2) step('0, 1'b0);
        step(LD, 1'b0);
        repeat (9) step('0, 1'b0);

        for (int k = 0; k < 400; k++) begin
            logic [5:0] o;
            case ($urandom_range(0, 5))
                0: o = JMP;
                1: o = LD;
                2: o = HLT;
                default: o = 6'($urandom());
            endcase
            step(o, ($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 59) == 0) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
